countdown_timer: RTL and testbench

- Loadable minutes/seconds/hundredths countdown timer; counterpart to the free-running up-counting stopwatch.
- Counts down from a preset to 0:00.00 and then flags expiry. Used for game rounds and timeouts.
- Output field widths match the stopwatch display path, so both can share the same display and formatting logic.

---
 rtl/countdown_timer_if.sv | 30 +++
 rtl/countdown_timer.sv | 129 ++++++++++++
 tb/tb_countdown_timer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Command/preset and display-count bundle for countdown_timer.
// The master drives presets and commands; the slave (the timer) drives the count and status flags.
interface countdown_timer_if;
  logic       load_in;
  logic [3:0] min_preset_in;
  logic [5:0] sec_preset_in;
  logic [6:0] hun_preset_in;
  logic       start_in;
  logic       pause_in;
  logic       clear_in;

  logic [3:0] minutes;
  logic [5:0] seconds;
  logic [6:0] hundredths;
  logic       running_out;
  logic       expired_out;
  logic       done_pulse_out;

  modport master (
    output load_in, min_preset_in, sec_preset_in, hun_preset_in,
    output start_in, pause_in, clear_in,
    input  minutes, seconds, hundredths, running_out, expired_out, done_pulse_out
  );

  modport slave (
    input  load_in, min_preset_in, sec_preset_in, hun_preset_in,
    input  start_in, pause_in, clear_in,
    output minutes, seconds, hundredths, running_out, expired_out, done_pulse_out
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable mm:ss.hh countdown timer with pause/resume, expiry flag and a one-cycle done pulse.
// Field widths match the stopwatch display path so both can share formatting logic.
module countdown_timer #(
  parameter int FREQUENCY = 100_000_000  // must be a multiple of 100 and >= 200
) (
  input logic             clk_in,
  input logic             rst_n_in,
  countdown_timer_if.slave tmr
);

  localparam int T  = FREQUENCY / 100;
  localparam int PW = $clog2(T);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    min_q;
  logic [5:0]    sec_q;
  logic [6:0]    hun_q;
  logic          running_q;
  logic          expired_q;
  logic          done_q;

  logic count_zero;
  logic tick;
  logic last_tick;

  assign count_zero = (min_q == 4'd0) && (sec_q == 6'd0) && (hun_q == 7'd0);
  assign tick       = (presc == PW'(T - 1));
  // The decrement that lands on 0:00.00 is the one made from 0:00.01.
  assign last_tick  = (min_q == 4'd0) && (sec_q == 6'd0) && (hun_q == 7'd1);

  // NOTE: every register here is assigned with <= so all branches see pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      presc     <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      hun_q     <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tmr.clear_in) begin
        state     <= IDLE;
        presc     <= '0;
        min_q     <= '0;
        sec_q     <= '0;
        hun_q     <= '0;
        running_q <= 1'b0;
        expired_q <= 1'b0;
      end else if (tmr.load_in && state != RUNNING) begin
        state     <= IDLE;
        presc     <= '0;
        min_q     <= tmr.min_preset_in;
        sec_q     <= (tmr.sec_preset_in > 6'd59) ? 6'd59 : tmr.sec_preset_in;
        hun_q     <= (tmr.hun_preset_in > 7'd99) ? 7'd99 : tmr.hun_preset_in;
        running_q <= 1'b0;
        expired_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (tmr.start_in && !tmr.pause_in && !count_zero) begin
              state     <= RUNNING;
              presc     <= '0;
              running_q <= 1'b1;
            end
          end
          RUNNING: begin
            if (tick) begin
              // A decrement on the pause edge still applies; expiry outranks pause.
              presc <= '0;
              if (hun_q != 7'd0) begin
                hun_q <= hun_q - 7'd1;
              end else begin
                hun_q <= 7'd99;
                if (sec_q != 6'd0) begin
                  sec_q <= sec_q - 6'd1;
                end else begin
                  sec_q <= 6'd59;
                  min_q <= min_q - 4'd1;
                end
              end
              if (last_tick) begin
                state     <= EXPIRED;
                running_q <= 1'b0;
                expired_q <= 1'b1;
                done_q    <= 1'b1;
              end else if (tmr.pause_in) begin
                state     <= PAUSED;
                running_q <= 1'b0;
              end
            end else if (tmr.pause_in) begin
              // Prescaler is held so resuming preserves total elapsed cycles.
              state     <= PAUSED;
              running_q <= 1'b0;
            end else begin
              presc <= presc + PW'(1);
            end
          end
          PAUSED: begin
            if (tmr.start_in && !tmr.pause_in) begin
              state     <= RUNNING;
              running_q <= 1'b1;
            end
          end
          EXPIRED: begin
          end
          default: begin
            state     <= IDLE;
            running_q <= 1'b0;
            expired_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tmr.minutes        = min_q;
  assign tmr.seconds        = sec_q;
  assign tmr.hundredths     = hun_q;
  assign tmr.running_out    = running_q;
  assign tmr.expired_out    = expired_q;
  assign tmr.done_pulse_out = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table, directed corner sequences and
// randomized commands compared each cycle against a total-hundredths reference model.
module tb_countdown_timer;

  localparam int FREQ = 1000;
  localparam int T    = FREQ / 100;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;

  countdown_timer_if tif ();

  countdown_timer #(.FREQUENCY(FREQ)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .tmr      (tif)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: remaining time as one integer of hundredths, plus elapsed cycles in the current tick.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXP} mode_t;
  mode_t m_mode;
  int    m_total;
  int    m_phase;
  bit    m_done;

  function automatic void model_reset();
    m_mode  = M_IDLE;
    m_total = 0;
    m_phase = 0;
    m_done  = 1'b0;
  endfunction

  function automatic void model_step(bit ld, int mn, int sc, int hn, bit st, bit ps, bit cl);
    m_done = 1'b0;
    if (cl) begin
      m_total = 0;
      m_phase = 0;
      m_mode  = M_IDLE;
    end else if (ld && m_mode != M_RUN) begin
      m_total = mn * 6000 + ((sc > 59) ? 59 : sc) * 100 + ((hn > 99) ? 99 : hn);
      m_phase = 0;
      m_mode  = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE:  if (st && !ps && m_total > 0) begin m_mode = M_RUN; m_phase = 0; end
        M_RUN: begin
          if (m_phase == T - 1) begin
            m_phase = 0;
            m_total = m_total - 1;
          end else if (!ps) begin
            m_phase = m_phase + 1;
          end
          if (m_total == 0) begin
            m_mode = M_EXP;
            m_done = 1'b1;
          end else if (ps) begin
            m_mode = M_PAUSE;
          end
        end
        M_PAUSE: if (st && !ps) m_mode = M_RUN;
        default: ;
      endcase
    end
  endfunction

  function automatic logic [19:0] model_out();
    return {4'(m_total / 6000), 6'((m_total / 100) % 60), 7'(m_total % 100),
            m_mode == M_RUN, m_mode == M_EXP, m_done};
  endfunction

  function automatic logic [19:0] dut_out();
    return {tif.minutes, tif.seconds, tif.hundredths,
            tif.running_out, tif.expired_out, tif.done_pulse_out};
  endfunction

  function automatic logic [19:0] pack(int mn, int sc, int hn, bit r, bit e, bit d);
    return {4'(mn), 6'(sc), 7'(hn), r, e, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge with the given commands, then a model comparison 1 time unit after the edge.
  task automatic step(input bit ld, input int mn, input int sc, input int hn,
                      input bit st, input bit ps, input bit cl);
    tif.load_in       = ld;
    tif.min_preset_in = 4'(mn);
    tif.sec_preset_in = 6'(sc);
    tif.hun_preset_in = 7'(hn);
    tif.start_in      = st;
    tif.pause_in      = ps;
    tif.clear_in      = cl;
    @(posedge clk_in);
    model_step(ld, mn, sc, hn, st, ps, cl);
    #1;
    check("model", 32'(dut_out()), 32'(model_out()));
    tif.load_in  = 1'b0;
    tif.start_in = 1'b0;
    tif.pause_in = 1'b0;
    tif.clear_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_load(input int mn, input int sc, input int hn);
    step(1, mn, sc, hn, 0, 0, 0);
  endtask
  task automatic do_start(); step(0, 0, 0, 0, 1, 0, 0); endtask
  task automatic do_pause(); step(0, 0, 0, 0, 0, 1, 0); endtask
  task automatic do_clear(); step(0, 0, 0, 0, 0, 0, 1); endtask

  typedef struct {
    bit ld; int mn; int sc; int hn; bit st; bit ps; bit cl;
    int e_min; int e_sec; int e_hun; bit e_run; bit e_exp; bit e_done;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tif.load_in = 0; tif.start_in = 0; tif.pause_in = 0; tif.clear_in = 0;
    tif.min_preset_in = 0; tif.sec_preset_in = 0; tif.hun_preset_in = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_outputs", 32'(dut_out()), 32'h0);
    rst_n_in = 1'b1;

    // Vector table, applied from the reset state
    vecs.push_back('{1, 2, 63, 120, 0, 0, 0,  2, 59, 99, 0, 0, 0});  // clamped load
    vecs.push_back('{0, 0,  0,   0, 1, 0, 0,  2, 59, 99, 1, 0, 0});  // start
    vecs.push_back('{1, 0,  0,   5, 0, 0, 0,  2, 59, 99, 1, 0, 0});  // load ignored while running
    vecs.push_back('{0, 0,  0,   0, 0, 1, 0,  2, 59, 99, 0, 0, 0});  // pause
    vecs.push_back('{1, 0,  0,   0, 0, 0, 0,  0,  0,  0, 0, 0, 0});  // load zero from PAUSED
    vecs.push_back('{0, 0,  0,   0, 1, 0, 0,  0,  0,  0, 0, 0, 0});  // start on zero ignored
    vecs.push_back('{0, 0,  0,   0, 1, 0, 0,  0,  0,  0, 0, 0, 0});
    vecs.push_back('{1, 15, 59, 99, 0, 0, 0, 15, 59, 99, 0, 0, 0});  // max load
    vecs.push_back('{0, 0,  0,   0, 1, 0, 1,  0,  0,  0, 0, 0, 0});  // clear beats start
    vecs.push_back('{1, 1,  0,   0, 0, 0, 0,  1,  0,  0, 0, 0, 0});
    vecs.push_back('{1, 3,  3,   3, 0, 0, 1,  0,  0,  0, 0, 0, 0});  // clear beats load
    vecs.push_back('{1, 0,  1,   0, 0, 0, 0,  0,  1,  0, 0, 0, 0});
    vecs.push_back('{0, 0,  0,   0, 1, 0, 0,  0,  1,  0, 1, 0, 0});
    vecs.push_back('{0, 0,  0,   0, 0, 0, 1,  0,  0,  0, 0, 0, 0});  // clear while running
    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].mn, vecs[i].sc, vecs[i].hn, vecs[i].st, vecs[i].ps, vecs[i].cl);
      check($sformatf("vec%0d", i), 32'(dut_out()),
            32'(pack(vecs[i].e_min, vecs[i].e_sec, vecs[i].e_hun,
                     vecs[i].e_run, vecs[i].e_exp, vecs[i].e_done)));
    end

    // Countdown from 0:00.03 with decrements every T cycles, then expiry
    do_load(0, 0, 3);
    do_start();
    idle(T - 1);
    check("t1_before_first_dec", 32'(tif.hundredths), 32'd3);
    idle(1);
    check("t1_first_dec", 32'(tif.hundredths), 32'd2);
    idle(T);
    check("t1_second_dec", 32'(tif.hundredths), 32'd1);
    idle(T);
    check("t1_expire", 32'(dut_out()), 32'(pack(0, 0, 0, 0, 1, 1)));
    idle(1);
    check("t1_done_one_cycle", 32'(dut_out()), 32'(pack(0, 0, 0, 0, 1, 0)));
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(3);
    check("t1_expired_holds", 32'(dut_out()), 32'(pack(0, 0, 0, 0, 1, 0)));

    // Both borrows
    do_load(1, 0, 0);
    do_start();
    idle(T);
    check("t2_minute_borrow", 32'(dut_out()), 32'(pack(0, 59, 99, 1, 0, 0)));
    do_pause();
    do_load(0, 1, 0);
    do_start();
    idle(T);
    check("t2_second_borrow", 32'(dut_out()), 32'(pack(0, 0, 99, 1, 0, 0)));
    do_clear();

    // Pause with prescaler at 4, hold, resume: next decrement 6 cycles after resume
    do_load(0, 5, 0);
    do_start();
    idle(4);
    do_pause();
    idle(50);
    check("t4_paused_frozen", 32'(dut_out()), 32'(pack(0, 5, 0, 0, 0, 0)));
    do_start();
    idle(5);
    check("t4_no_early_dec", 32'(dut_out()), 32'(pack(0, 5, 0, 1, 0, 0)));
    idle(1);
    check("t4_dec_after_resume", 32'(dut_out()), 32'(pack(0, 4, 99, 1, 0, 0)));
    do_load(9, 9, 9);
    check("t4_load_while_running", 32'(dut_out()), 32'(pack(0, 4, 99, 1, 0, 0)));
    do_clear();

    // Pause coincident with the final decrement, then clear+start together
    do_load(0, 0, 1);
    do_start();
    idle(T - 1);
    do_pause();
    check("t5_pause_on_final_dec", 32'(dut_out()), 32'(pack(0, 0, 0, 0, 1, 1)));
    step(0, 0, 0, 0, 1, 0, 1);
    check("t5_clear_start", 32'(dut_out()), 32'(pack(0, 0, 0, 0, 0, 0)));

    // Asynchronous reset between clock edges while running
    do_load(0, 10, 0);
    do_start();
    idle(13);
    @(posedge clk_in);
    #3;
    rst_n_in = 1'b0;
    #1;
    check("t6_async_reset", 32'(dut_out()), 32'h0);
    model_reset();
    #2;
    rst_n_in = 1'b1;
    idle(1);
    check("t6_idle_after_reset", 32'(dut_out()), 32'h0);
    do_load(0, 0, 5);
    do_start();
    check("t6_start_from_idle", 32'(tif.running_out), 32'd1);
    do_clear();

    // Randomized commands against the reference model
    for (int i = 0; i < 2000; i++) begin
      int r;
      bit ld, st, ps, cl;
      int mn, sc, hn;
      r  = $urandom_range(0, 99);
      ld = (r < 5);
      st = (r >= 5 && r < 17);
      ps = (r >= 17 && r < 22);
      cl = (r == 22);
      if ($urandom_range(0, 1) == 0) begin
        mn = 0;
        sc = 0;
        hn = $urandom_range(0, 20);
      end else begin
        mn = $urandom_range(0, 15);
        sc = $urandom_range(0, 63);
        hn = $urandom_range(0, 127);
      end
      step(ld, mn, sc, hn, st, ps, cl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
